// File: rtl/image_frame_feeder_if.sv
// Stream bundle for the frame feeder: pixel input (s_*) and pixel output (m_*).
// The feeder side uses the master modport, the environment uses slave.
interface image_frame_feeder_if #(
    parameter int DATA_W = 32
);
    logic              s_tvalid;
    logic              s_tready;
    logic [DATA_W-1:0] s_tdata;
    logic              m_tvalid;
    logic              m_tready;
    logic              m_tlast;
    logic [DATA_W-1:0] m_tdata;

    modport master (
        input  s_tvalid, s_tdata, m_tready,
        output s_tready, m_tvalid, m_tdata, m_tlast
    );

    modport slave (
        output s_tvalid, s_tdata, m_tready,
        input  s_tready, m_tvalid, m_tdata, m_tlast
    );
endinterface

// File: rtl/image_frame_feeder.sv
// Buffers incoming pixels in a FIFO and streams them out as a run of fixed-length
// frames per start pulse, optionally thresholding each pixel to a single bit.
module image_frame_feeder #(
    parameter int                        DATA_W    = 32,
    parameter int                        FRAME_LEN = 784,
    parameter int                        DEPTH     = 16,
    parameter bit                        BINARIZE  = 1'b0,
    parameter logic signed [DATA_W-1:0]  THRESH    = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [7:0]                    num_frames,
    image_frame_feeder_if.master          bus,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          all_done,
    output logic [$clog2(FRAME_LEN)-1:0]  pix_cnt,
    output logic [7:0]                    frame_cnt,
    output logic [$clog2(DEPTH):0]        level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int PW = $clog2(FRAME_LEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e            state_q;
    logic [7:0]        frames_left_q;
    logic [PW-1:0]     pix_cnt_q;
    logic [7:0]        frame_cnt_q;
    logic              busy_q;
    logic              frame_done_q;
    logic              all_done_q;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wptr_q;
    logic [AW-1:0]     wptr_d;
    logic [AW-1:0]     rptr_q;
    logic [AW-1:0]     rptr_d;
    logic [LW-1:0]     level_q;
    logic [LW-1:0]     level_d;

    logic              full_s;
    logic              empty_s;
    logic              s_tready_s;
    logic              m_tvalid_s;
    logic              push_s;
    logic              pop_s;
    logic              last_s;
    logic [DATA_W-1:0] head_s;

    // Handshake decode and FIFO next-state; a push and a pop in one cycle leave level unchanged
    always_comb begin
        full_s     = (level_q == LW'(DEPTH));
        empty_s    = (level_q == '0);
        s_tready_s = !full_s && !rst;
        m_tvalid_s = (state_q == RUN) && !empty_s;
        last_s     = (pix_cnt_q == PW'(FRAME_LEN - 1));
        push_s     = bus.s_tvalid && s_tready_s;
        pop_s      = m_tvalid_s && bus.m_tready;
        wptr_d     = wptr_q + AW'(push_s);
        rptr_d     = rptr_q + AW'(pop_s);
        level_d    = level_q + LW'(push_s) - LW'(pop_s);
        head_s     = mem_q[rptr_q];
    end

    // FIFO storage; contents need no reset because level gates visibility
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wptr_q] <= bus.s_tdata;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    // Sequence control: frame/pixel counters and the one-cycle status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            frames_left_q <= 8'd0;
            pix_cnt_q     <= '0;
            frame_cnt_q   <= 8'd0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            all_done_q    <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            all_done_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q       <= RUN;
                        busy_q        <= 1'b1;
                        frames_left_q <= (num_frames == 8'd0) ? 8'd1 : num_frames;
                        pix_cnt_q     <= '0;
                        frame_cnt_q   <= 8'd0;
                    end
                end
                RUN: begin
                    if (pop_s) begin
                        if (last_s) begin
                            pix_cnt_q     <= '0;
                            frame_cnt_q   <= frame_cnt_q + 8'd1;
                            frame_done_q  <= 1'b1;
                            frames_left_q <= frames_left_q - 8'd1;
                            if (frames_left_q == 8'd1) begin
                                state_q    <= DONE;
                                all_done_q <= 1'b1;
                            end
                        end else begin
                            pix_cnt_q <= pix_cnt_q + PW'(1);
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // The head word only changes on a pop, so output data holds across stalls
    if (BINARIZE) begin : g_bin
        assign bus.m_tdata = {{(DATA_W - 1){1'b0}}, ($signed(head_s) > THRESH)};
    end else begin : g_pass
        assign bus.m_tdata = head_s;
    end

    assign bus.s_tready = s_tready_s;
    assign bus.m_tvalid = m_tvalid_s;
    assign bus.m_tlast  = m_tvalid_s && last_s;
    assign busy         = busy_q;
    assign frame_done   = frame_done_q;
    assign all_done     = all_done_q;
    assign pix_cnt      = pix_cnt_q;
    assign frame_cnt    = frame_cnt_q;
    assign level        = level_q;
endmodule

// File: tb/tb_image_frame_feeder.sv
// Bench for image_frame_feeder: three instances (default frame, short frame, binarizing)
// driven through one selectable stimulus port and checked against a queue model.
module tb_image_frame_feeder;
    logic        clk = 1'b0;
    logic        rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
    logic [1:0]  sel = 2'd0;
    logic        start_t = 1'b0;
    logic [7:0]  nf_t = 8'd0;
    logic        s_tvalid_t = 1'b0;
    logic [31:0] s_tdata_t = 32'd0;
    logic        m_tready_t = 1'b0;

    int checks = 0;
    int failures = 0;
    logic [31:0] mdl_q[$];

    always #5 clk = ~clk;

    image_frame_feeder_if #(.DATA_W(32)) ifa ();
    image_frame_feeder_if #(.DATA_W(32)) ifb ();
    image_frame_feeder_if #(.DATA_W(32)) ifc ();

    assign ifa.s_tvalid = (sel == 2'd0) && s_tvalid_t;
    assign ifb.s_tvalid = (sel == 2'd1) && s_tvalid_t;
    assign ifc.s_tvalid = (sel == 2'd2) && s_tvalid_t;
    assign ifa.m_tready = (sel == 2'd0) && m_tready_t;
    assign ifb.m_tready = (sel == 2'd1) && m_tready_t;
    assign ifc.m_tready = (sel == 2'd2) && m_tready_t;
    assign ifa.s_tdata  = s_tdata_t;
    assign ifb.s_tdata  = s_tdata_t;
    assign ifc.s_tdata  = s_tdata_t;

    logic       busy_a, busy_b, busy_c, fd_a, fd_b, fd_c, ad_a, ad_b, ad_c;
    logic [9:0] pix_a;
    logic [2:0] pix_b;
    logic [1:0] pix_c;
    logic [7:0] fc_a, fc_b, fc_c;
    logic [4:0] lvl_a, lvl_b, lvl_c;

    image_frame_feeder #(.DATA_W(32), .FRAME_LEN(784), .DEPTH(16)) dut_a (
        .clk(clk), .rst(rst_a), .start((sel == 2'd0) && start_t), .num_frames(nf_t),
        .bus(ifa.master), .busy(busy_a), .frame_done(fd_a), .all_done(ad_a),
        .pix_cnt(pix_a), .frame_cnt(fc_a), .level(lvl_a));

    image_frame_feeder #(.DATA_W(32), .FRAME_LEN(8), .DEPTH(16)) dut_b (
        .clk(clk), .rst(rst_b), .start((sel == 2'd1) && start_t), .num_frames(nf_t),
        .bus(ifb.master), .busy(busy_b), .frame_done(fd_b), .all_done(ad_b),
        .pix_cnt(pix_b), .frame_cnt(fc_b), .level(lvl_b));

    image_frame_feeder #(.DATA_W(32), .FRAME_LEN(4), .DEPTH(16), .BINARIZE(1'b1),
                         .THRESH(32'sd0)) dut_c (
        .clk(clk), .rst(rst_c), .start((sel == 2'd2) && start_t), .num_frames(nf_t),
        .bus(ifc.master), .busy(busy_c), .frame_done(fd_c), .all_done(ad_c),
        .pix_cnt(pix_c), .frame_cnt(fc_c), .level(lvl_c));

    logic        o_str, o_mv, o_ml, o_busy, o_fd, o_ad;
    logic [31:0] o_md;
    logic [15:0] o_pix;
    logic [7:0]  o_fc;
    logic [4:0]  o_lvl;

    // View of whichever instance is currently selected
    always_comb begin
        case (sel)
            2'd1: begin
                o_str = ifb.s_tready; o_mv = ifb.m_tvalid; o_ml = ifb.m_tlast; o_md = ifb.m_tdata;
                o_busy = busy_b; o_fd = fd_b; o_ad = ad_b; o_pix = 16'(pix_b); o_fc = fc_b; o_lvl = lvl_b;
            end
            2'd2: begin
                o_str = ifc.s_tready; o_mv = ifc.m_tvalid; o_ml = ifc.m_tlast; o_md = ifc.m_tdata;
                o_busy = busy_c; o_fd = fd_c; o_ad = ad_c; o_pix = 16'(pix_c); o_fc = fc_c; o_lvl = lvl_c;
            end
            default: begin
                o_str = ifa.s_tready; o_mv = ifa.m_tvalid; o_ml = ifa.m_tlast; o_md = ifa.m_tdata;
                o_busy = busy_a; o_fd = fd_a; o_ad = ad_a; o_pix = 16'(pix_a); o_fc = fc_a; o_lvl = lvl_a;
            end
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Stream a sequence through the selected instance and compare every cycle with the model.
    // mode: 0 = ramp idx, 1 = random, 2 = table {-5,0,1,32767} then random.
    task automatic run_stream(input int mode, input int n_words, input int nf, input int fl,
                              input int rdy_pct, input int val_pct, input bit binar,
                              input int stop_at, input bit start_mid, input int budget);
        int fr, total, cyc, out_cnt, idx, post;
        bit started, running, done, fd_exp, ad_exp, stall, st_l;
        logic [31:0] st_d, w, ew;
        logic [31:0] tbl [4];
        tbl[0] = 32'hFFFF_FFFB; tbl[1] = 32'd0; tbl[2] = 32'd1; tbl[3] = 32'd32767;
        fr = (nf == 0) ? 1 : nf;
        total = fr * fl;
        cyc = 0; out_cnt = 0; idx = 0; post = 0;
        started = 1'b0; done = 1'b0; fd_exp = 1'b0; ad_exp = 1'b0; stall = 1'b0;
        st_d = 32'd0; st_l = 1'b0;
        while (!done) begin
            @(negedge clk);
            start_t    = (cyc == 0) || (start_mid && cyc == 20);
            nf_t       = 8'(nf);
            s_tvalid_t = (idx < n_words) && ($urandom_range(99) < val_pct);
            if (mode == 0) s_tdata_t = 32'(idx);
            else if (mode == 2 && idx < 4) s_tdata_t = tbl[idx];
            else s_tdata_t = $urandom;
            m_tready_t = ($urandom_range(99) < rdy_pct);
            #1;
            running = started && (out_cnt < total);
            check("busy", 32'(o_busy), 32'(running || ad_exp));
            check("m_tvalid", 32'(o_mv), 32'(running && mdl_q.size() > 0));
            check("level", 32'(o_lvl), 32'(mdl_q.size()));
            check("frame_done", 32'(o_fd), 32'(fd_exp));
            check("all_done", 32'(o_ad), 32'(ad_exp));
            if (!o_mv) check("m_tlast_idle", 32'(o_ml), 32'd0);
            if (stall) begin
                check("hold_data", o_md, st_d);
                check("hold_last", 32'(o_ml), 32'(st_l));
            end
            fd_exp = 1'b0;
            ad_exp = 1'b0;
            stall = o_mv && !m_tready_t;
            st_d = o_md;
            st_l = o_ml;
            if (o_mv && m_tready_t && mdl_q.size() > 0) begin
                w = mdl_q.pop_front();
                ew = binar ? (($signed(w) > 32'sd0) ? 32'd1 : 32'd0) : w;
                check("m_tdata", o_md, ew);
                check("m_tlast", 32'(o_ml), 32'((out_cnt % fl) == fl - 1));
                check("pix_cnt", 32'(o_pix), 32'(out_cnt % fl));
                if ((out_cnt % fl) == fl - 1) fd_exp = 1'b1;
                out_cnt++;
                if (out_cnt == total) ad_exp = 1'b1;
            end
            if (o_str && s_tvalid_t) begin
                mdl_q.push_back(s_tdata_t);
                idx++;
            end
            if (cyc == 0) started = 1'b1;
            cyc++;
            if (stop_at > 0 && out_cnt == stop_at) done = 1'b1;
            if (out_cnt == total) begin
                post++;
                if (post > 2) done = 1'b1;
            end
            if (cyc > budget) begin
                check("timeout_outputs", 32'(out_cnt), 32'(total));
                done = 1'b1;
            end
        end
        if (stop_at == 0) begin
            check("frame_cnt_end", 32'(o_fc), 32'(fr));
            check("pix_cnt_end", 32'(o_pix), 32'd0);
        end
        @(negedge clk);
        start_t = 1'b0; s_tvalid_t = 1'b0; m_tready_t = 1'b0;
    endtask

    initial begin
        int acc;
        // Reset all instances and check the reset state of the default one
        repeat (2) @(negedge clk);
        #1;
        check("rst_s_tready", 32'(o_str), 32'd0);
        check("rst_level", 32'(o_lvl), 32'd0);
        check("rst_m_tvalid", 32'(o_mv), 32'd0);
        check("rst_m_tlast", 32'(o_ml), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_frame_done", 32'(o_fd), 32'd0);
        check("rst_all_done", 32'(o_ad), 32'd0);
        check("rst_pix_cnt", 32'(o_pix), 32'd0);
        check("rst_frame_cnt", 32'(o_fc), 32'd0);
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        #1;
        check("post_rst_s_tready", 32'(o_str), 32'd1);

        // Fill without start: FIFO stops accepting at DEPTH
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            s_tvalid_t = 1'b1;
            s_tdata_t = 32'(i);
            #1;
            if (o_str) acc++;
        end
        @(negedge clk);
        s_tvalid_t = 1'b0;
        #1;
        check("fill_accepted", 32'(acc), 32'd16);
        check("fill_level", 32'(o_lvl), 32'd16);
        check("fill_s_tready", 32'(o_str), 32'd0);
        check("fill_m_tvalid", 32'(o_mv), 32'd0);

        @(negedge clk); rst_a = 1'b1;
        @(negedge clk); rst_a = 1'b0;
        mdl_q.delete();
        #1;
        check("rerst_level", 32'(o_lvl), 32'd0);

        // Full 784-pixel ramp frame with continuous handshakes
        run_stream(0, 784, 1, 784, 100, 100, 1'b0, 0, 1'b0, 4000);

        // Partial frame interrupted by reset at pixel 100
        run_stream(1, 300, 1, 784, 100, 100, 1'b0, 100, 1'b0, 2000);
        @(negedge clk); rst_a = 1'b1;
        @(negedge clk); rst_a = 1'b0;
        mdl_q.delete();
        #1;
        check("midrst_level", 32'(o_lvl), 32'd0);
        check("midrst_m_tvalid", 32'(o_mv), 32'd0);
        check("midrst_frame_done", 32'(o_fd), 32'd0);
        check("midrst_all_done", 32'(o_ad), 32'd0);
        check("midrst_pix_cnt", 32'(o_pix), 32'd0);
        @(negedge clk);
        #1;
        check("midrst_frame_done2", 32'(o_fd), 32'd0);
        check("midrst_all_done2", 32'(o_ad), 32'd0);

        // num_frames=0 emits one frame; a start during RUN is ignored
        run_stream(0, 784, 0, 784, 70, 80, 1'b0, 0, 1'b1, 6000);

        // Short frames with random backpressure; leftovers carry into the next start
        sel = 2'd1;
        mdl_q.delete();
        run_stream(1, 29, 3, 8, 60, 60, 1'b0, 0, 1'b0, 2000);
        run_stream(1, 16, 2, 8, 50, 70, 1'b0, 0, 1'b0, 2000);

        // Binarizing instance: fixed table then random signed data
        sel = 2'd2;
        mdl_q.delete();
        run_stream(2, 12, 3, 4, 100, 100, 1'b1, 0, 1'b0, 500);
        run_stream(1, 8, 2, 4, 50, 50, 1'b1, 0, 1'b0, 500);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
